// File: rtl/mem_bus_pkg.sv
// Shared encodings and field widths for the two-master memory bus arbiter.
package mem_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // Returned on watchdog termination so a fetching CPU traps.
    localparam logic [DATA_W-1:0] ILLEGAL_INSTRUCTION = 32'h0;

    typedef struct packed {
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } bus_req_t;

endpackage

// File: rtl/mem_bus_timeout.sv
// Hung-transaction watchdog: counts granted cycles without a slave response.
module mem_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 16'd1;
    end

    assign expire = enable && (count == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master valid/ready arbiter with registered grant and locked ownership.
// Optional watchdog enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_valid,
    input  logic              m0_instr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [STRB_W-1:0] m0_wstrb,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic              m1_instr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_valid,
    output logic              s_instr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] s_rdata,
    output logic [1:0]        grant,
    output logic              bus_error
);

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("mem_bus_arbiter: TIMEOUT_CYCLES must be in 2..65535");
        end
    endgenerate

    state_t   state, state_nxt;
    logic     last_grant, last_grant_nxt;  // 0 = M0 served last, 1 = M1
    logic     own_valid, resp, expire;
    logic [DATA_W-1:0] resp_data;
    bus_req_t m0_req, m1_req, s_req;

    assign m0_req = '{instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign m1_req = '{instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
    assign {s_instr, s_addr, s_wdata, s_wstrb} = s_req;

`ifdef MEM_BUS_TIMEOUT_EN
    mem_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (state == IDLE),
        .enable ((state != IDLE) && !s_ready),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        grant          = GRANT_NONE;
        s_req          = '0;
        s_valid        = 1'b0;
        m0_ready       = 1'b0;
        m1_ready       = 1'b0;
        m0_rdata       = '0;
        m1_rdata       = '0;
        bus_error      = 1'b0;
        own_valid      = 1'b0;
        resp           = 1'b0;
        resp_data      = '0;
        case (state)
            IDLE: begin
                if (m0_valid && m1_valid)
                    state_nxt = (FIXED_PRIORITY != 0 || last_grant) ? GNT0 : GNT1;
                else if (m0_valid)
                    state_nxt = GNT0;
                else if (m1_valid)
                    state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                grant     = (state == GNT1) ? GRANT_M1 : GRANT_M0;
                own_valid = (state == GNT1) ? m1_valid : m0_valid;
                s_req     = (state == GNT1) ? m1_req : m0_req;
                // expire only fires without s_ready, so a real response always wins
                s_valid   = own_valid && !expire;
                resp      = own_valid && (s_ready || expire);
                resp_data = s_ready ? s_rdata : ILLEGAL_INSTRUCTION;
                bus_error = own_valid && expire;
                if (state == GNT1) begin
                    m1_ready = resp;
                    m1_rdata = resp ? resp_data : '0;
                end else begin
                    m0_ready = resp;
                    m0_rdata = resp ? resp_data : '0;
                end
                // a dropped request abandons the slot without touching fairness
                if (!own_valid || resp)
                    state_nxt = IDLE;
                if (resp)
                    last_grant_nxt = (state == GNT1);
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter for the CPU memory bus, sharing the single downstream valid/ready bus between master 0 (CPU) and master 1 (DMA/debug).
- The downstream bus is the application FPGA address decoder/mux that drives ROM, RAM, FW_RAM and MMIO cores.
- Registered grant, round-robin or fixed priority; a granted transaction is locked until the slave responds.
- Optional watchdog terminates hung transactions with an illegal-instruction response.

Parameters:
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = master 0 always wins a simultaneous request.
- TIMEOUT_CYCLES, 1024, cycles in a granted state without s_ready before forced termination (used only with the optional feature); legal range 2..65535.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- m0_valid / m1_valid  in  1  request valid; held until the matching mX_ready
- m0_instr / m1_instr  in  1  instruction fetch qualifier
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_wstrb / m1_wstrb  in  4  byte write strobes; 0 = read
- m0_ready / m1_ready  out  1  single-cycle completion pulse
- m0_rdata / m1_rdata  out  32  read data, valid with mX_ready
- s_valid  out  1  request to slave bus
- s_instr  out  1  forwarded instr qualifier
- s_addr  out  32  forwarded address
- s_wdata  out  32  forwarded write data
- s_wstrb  out  4  forwarded write strobes
- s_ready  in  1  slave completion pulse
- s_rdata  in  32  slave read data
- grant  out  2  one-hot current owner; 00 = idle
- bus_error  out  1  one-cycle pulse on timeout termination

Behaviour:
- Reset (reset_n low at posedge):
  - state=IDLE, grant=00, last_grant=M1 (so M0 wins the first round-robin tie).
  - s_valid=0, s_instr/addr/wdata/wstrb=0, m0/m1_ready=0, m0/m1_rdata=0, bus_error=0, timeout count=0.
  - Reset mid-transaction abandons it silently; no ready is issued.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - s_valid=0.
  - If only one mX_valid, the next state is GNTX.
  - If both: with FIXED_PRIORITY=1, GNT0; otherwise the master not equal to last_grant.
  - Arbitration costs exactly 1 cycle; a request raised in cycle N is visible on s_valid in cycle N+1.
- GNTX:
  - s_* mirror mX_* combinationally; s_valid = mX_valid.
  - mX_ready = s_ready and mX_rdata = s_rdata, both combinational.
  - The other master sees ready=0 and rdata=0.
  - s_ready=1: next state IDLE, last_grant<=X.
  - mX_valid drops before s_ready (protocol violation): next state IDLE, no ready, last_grant unchanged.
  - A slave response arriving in that same cycle is discarded.
- Back-to-back: a master may re-request the cycle after its ready. Under round-robin it loses to a waiting peer.
  - Minimum issue interval per master is 2 cycles (IDLE + grant).
  - The downstream mux's registered ready adds its own latency.
- Non-owner requests are held off with no ready and no data.
- The data path has no registers; grant and state are the only registered control.
- mX_rdata is 0 whenever mX_ready=0.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to GNTX and increments each GNTX cycle without s_ready.
  - When the count equals TIMEOUT_CYCLES-1 and s_ready=0, that cycle:
    - mX_ready=1 and mX_rdata=32'h0 (illegal instruction, so the CPU traps).
    - s_valid is forced 0 and bus_error=1.
    - Next state IDLE, last_grant<=X.
  - If s_ready=1 in the terminal cycle, the normal response wins and bus_error=0.
- Undefined: no counter is built, bus_error is tied 0, and a hung slave stalls the owner indefinitely.

Decomposition:
- Package mem_bus_pkg holds:
  - State encodings IDLE/GNT0/GNT1.
  - Grant encodings GRANT_NONE=2'b00, GRANT_M0=2'b01, GRANT_M1=2'b10.
  - ILLEGAL_INSTRUCTION=32'h0.
  - Bus field widths ADDR_W=32, DATA_W=32, STRB_W=4.
- Sub-module mem_bus_timeout: counter with clear/enable/expire inputs and outputs, instantiated only under MEM_BUS_TIMEOUT_EN.

Test Plan:
- Reset release, then m0 reads 0x4000_0010, slave returns ready with rdata 0xDEADBEEF after 3 cycles.
  - Expect grant=01 the cycle after valid, s_addr=0x4000_0010.
  - Expect m0_ready pulse with rdata 0xDEADBEEF; m1_ready stays 0.
- m0 and m1 both valid from cycle 0, round-robin, each completes in 1 cycle, both re-request immediately.
  - Expect grant sequence 01,00,10,00,01,00,10.
  - Repeat with FIXED_PRIORITY=1: expect 01,00,01,00 and m1 starved.
- m1 writes wstrb=4'b0011, wdata=0x1234_5678 to 0xC300_0000 while m0 is idle.
  - Expect s_wstrb=0011, s_wdata=0x1234_5678, m1_ready pulse.
  - m0 requesting mid-transaction is not granted until after m1_ready.
- reset_n asserted in GNT0 before s_ready.
  - Expect the next cycle: grant=00, s_valid=0, no m0_ready.
  - After release, the pending m0 request is re-arbitrated normally.
- m0 drops valid in GNT0 before s_ready.
  - Expect IDLE next cycle, no ready.
  - m1 then waits exactly 1 further cycle before being granted.
- MEM_BUS_TIMEOUT_EN with TIMEOUT_CYCLES=8, slave never responds to m0.
  - Expect on the 8th GNT0 cycle: m0_ready=1, m0_rdata=0, bus_error=1, s_valid=0.
  - Repeat with s_ready on the 8th cycle: expect normal data and bus_error=0.
